// File: rtl/cube_pkg.sv
// Shared definitions for the cube matrix-engine sequencer.
//   - default loop-counter, address and pipe-latency widths
//   - sequencer state encoding
//   - tile-tag layout helpers for the tracking pipe
package cube_pkg;

   localparam int CNT_W_DEFAULT    = 8;
   localparam int ADDR_W_DEFAULT   = 16;
   localparam int PIPE_LAT_DEFAULT = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Tile tag is {valid, first, last, m, n}. The valid bit travels on its own
   // so it can be cleared by reset; the rest is the payload {first, last, m, n}
   // with n in the least-significant bits.
   localparam int TAG_FLAG_W = 2;

   function automatic int tag_payload_w(input int cnt_w);
      return TAG_FLAG_W + 2 * cnt_w;
   endfunction

   function automatic int tag_w(input int cnt_w);
      return 1 + tag_payload_w(cnt_w);
   endfunction

endpackage

// File: rtl/cube_tag_pipe.sv
// Tile-tag shift register that mirrors the operand-buffer plus cube latency.
// Ports:
//   clock       rising-edge clock
//   rst         async active-high reset, clears valid bits only
//   in_valid    tile issued this cycle
//   in_payload  {first, last, m, n} of the issued tile
//   valid_vec   valid bit of every stage, index 0 is the youngest
//   out_payload payload of the oldest stage
module cube_tag_pipe
   import cube_pkg::*;
#(
   parameter int DEPTH = PIPE_LAT_DEFAULT,
   parameter int PAY_W = tag_payload_w(CNT_W_DEFAULT)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [PAY_W-1:0] in_payload,
   output logic [DEPTH-1:0] valid_vec,
   output logic [PAY_W-1:0] out_payload
);

   logic [DEPTH-1:0] valid_q;
   logic [PAY_W-1:0] pay_q [DEPTH];

   // The cube has no enable, so the pipe shifts every cycle.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Payload is qualified by valid downstream, so it needs no reset.
   always_ff @(posedge clock) begin
      pay_q[0] <= in_payload;
      for (int i = 1; i < DEPTH; i++) begin
         pay_q[i] <= pay_q[i-1];
      end
   end

   assign valid_vec   = valid_q;
   assign out_payload = pay_q[DEPTH-1];

endmodule

// File: rtl/cube_seq_ctrl.sv
// Sequencer for the 8x8x8 cube matrix engine. Walks the M x N x K tile loop
// nest (k innermost, then n, then m), issues one A/B tile-pair read per
// un-stalled cycle and tags each tile through the buffer-plus-cube latency so
// the accumulator sideband lines up with acc_out.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; cfg checked and latched here
// RUN   | issuing tiles, one per cycle unless stalled
// DRAIN | all tiles issued, waiting for the tag pipe to empty
// DONE  | one-cycle done pulse, back to IDLE
//
// Ports:
//   clock, rst             clock and async active-high reset
//   start                  command pulse, sampled only in IDLE
//   cfg_m/cfg_n/cfg_k      tile counts, all must be nonzero
//   stall                  suppress issue this cycle
//   busy, done, cfg_err    job status
//   a_rd_en/a_rd_addr      pixel buffer read (m*cfg_k + k)
//   b_rd_en/b_rd_addr      weight buffer read (n*cfg_k + k)
//   acc_valid/first/last   accumulator control aligned with acc_out
//   acc_m/acc_n            coordinates of the aligned tile
module cube_seq_ctrl
   import cube_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEFAULT,
   parameter int ADDR_W   = ADDR_W_DEFAULT,
   parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_m,
   input  logic [CNT_W-1:0]  cfg_n,
   input  logic [CNT_W-1:0]  cfg_k,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_rd_addr,
   output logic              acc_valid,
   output logic              acc_first,
   output logic              acc_last,
   output logic [CNT_W-1:0]  acc_m,
   output logic [CNT_W-1:0]  acc_n
);

   localparam int PAY_W = tag_payload_w(CNT_W);

   // Every stage except the oldest. When these are empty in DRAIN, the pipe is
   // empty after this edge, which puts done exactly PIPE_LAT+1 after the last
   // issue.
   localparam logic [PIPE_LAT-1:0] EARLY_MASK = {PIPE_LAT{1'b1}} >> 1;

   seq_state_t state, state_nxt;

   logic issue;
   logic load_cfg;
   logic cfg_zero;
   logic k_wrap, n_wrap, m_wrap, is_last_tile;
   logic pipe_early_empty;
   logic cfg_err_q;

   logic [CNT_W-1:0]  cfg_m_q, cfg_n_q, cfg_k_q;
   logic [CNT_W-1:0]  m_q, n_q, k_q;
   logic [ADDR_W-1:0] a_base_q, b_base_q;
   logic [ADDR_W-1:0] k_ext, cfg_k_ext;

   logic [PIPE_LAT-1:0] valid_vec;
   logic [PAY_W-1:0]    tag_in, tag_out;

   assign cfg_zero = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);

   assign k_wrap       = (k_q == cfg_k_q - CNT_W'(1));
   assign n_wrap       = (n_q == cfg_n_q - CNT_W'(1));
   assign m_wrap       = (m_q == cfg_m_q - CNT_W'(1));
   assign is_last_tile = k_wrap && n_wrap && m_wrap;

   assign pipe_early_empty = ((valid_vec & EARLY_MASK) == '0);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      load_cfg  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !cfg_zero) begin
               load_cfg  = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               issue = 1'b1;
               if (is_last_tile) begin
                  state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pipe_early_empty) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Incremental addressing: a_base steps by cfg_k per n-wrap, b_base steps by
   // cfg_k per k-wrap and restarts at every n-wrap. No multipliers needed.
   assign k_ext     = ADDR_W'(k_q);
   assign cfg_k_ext = ADDR_W'(cfg_k_q);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         cfg_err_q <= 1'b0;
         cfg_m_q   <= '0;
         cfg_n_q   <= '0;
         cfg_k_q   <= '0;
         m_q       <= '0;
         n_q       <= '0;
         k_q       <= '0;
         a_base_q  <= '0;
         b_base_q  <= '0;
      end else begin
         cfg_err_q <= (state == ST_IDLE) && start && cfg_zero;
         if (load_cfg) begin
            cfg_m_q  <= cfg_m;
            cfg_n_q  <= cfg_n;
            cfg_k_q  <= cfg_k;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
         end else if (issue) begin
            if (k_wrap) begin
               k_q <= '0;
               if (n_wrap) begin
                  n_q      <= '0;
                  b_base_q <= '0;
                  a_base_q <= a_base_q + cfg_k_ext;
                  m_q      <= m_wrap ? '0 : m_q + CNT_W'(1);
               end else begin
                  n_q      <= n_q + CNT_W'(1);
                  b_base_q <= b_base_q + cfg_k_ext;
               end
            end else begin
               k_q <= k_q + CNT_W'(1);
            end
         end
      end
   end

   assign tag_in = {(k_q == '0), k_wrap, m_q, n_q};

   cube_tag_pipe #(
      .DEPTH (PIPE_LAT),
      .PAY_W (PAY_W)
   ) u_tag_pipe (
      .clock       (clock),
      .rst         (rst),
      .in_valid    (issue),
      .in_payload  (tag_in),
      .valid_vec   (valid_vec),
      .out_payload (tag_out)
   );

   assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
   assign done    = (state == ST_DONE);
   assign cfg_err = cfg_err_q;

   // Addresses are held at zero when no read is issued so idle buses stay quiet.
   assign a_rd_en   = issue;
   assign b_rd_en   = issue;
   assign a_rd_addr = issue ? (a_base_q + k_ext) : '0;
   assign b_rd_addr = issue ? (b_base_q + k_ext) : '0;

   // Payload flops have no reset, so sideband is qualified by the valid bit.
   assign acc_valid = valid_vec[PIPE_LAT-1];
   assign acc_first = acc_valid & tag_out[PAY_W-1];
   assign acc_last  = acc_valid & tag_out[PAY_W-2];
   assign acc_m     = acc_valid ? tag_out[2*CNT_W-1:CNT_W] : '0;
   assign acc_n     = acc_valid ? tag_out[CNT_W-1:0] : '0;

endmodule

// File: tb/tb_cube_seq_ctrl.sv
module tb_cube_seq_ctrl;

   localparam int PIPE_LAT = 3;

   logic        clock = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_m, cfg_n, cfg_k;
   logic        stall;
   logic        busy, done, cfg_err;
   logic        a_rd_en, b_rd_en;
   logic [15:0] a_rd_addr, b_rd_addr;
   logic        acc_valid, acc_first, acc_last;
   logic [7:0]  acc_m, acc_n;

   cube_seq_ctrl dut (
      .clock     (clock),
      .rst       (rst),
      .start     (start),
      .cfg_m     (cfg_m),
      .cfg_n     (cfg_n),
      .cfg_k     (cfg_k),
      .stall     (stall),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
      .a_rd_en   (a_rd_en),
      .a_rd_addr (a_rd_addr),
      .b_rd_en   (b_rd_en),
      .b_rd_addr (b_rd_addr),
      .acc_valid (acc_valid),
      .acc_first (acc_first),
      .acc_last  (acc_last),
      .acc_m     (acc_m),
      .acc_n     (acc_n)
   );

   typedef struct {
      int         due;
      logic       first;
      logic       last;
      logic [7:0] m;
      logic [7:0] n;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int job_m = 1, job_n = 1, job_k = 1;
   int mdl_m = 0, mdl_n = 0, mdl_k = 0;
   int issue_cnt = 0, first_issue_cyc = 0, last_issue_cyc = 0;
   int first_cnt = 0, last_cnt = 0, done_cnt = 0;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: predicts addresses from its own loop model, pushes the
   // expected accumulator tag PIPE_LAT cycles ahead, and pops it when due.
   always @(negedge clock) begin : mon
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("acc_valid", 32'(acc_valid), 1);
         chk("acc_first", 32'(acc_first), 32'(e.first));
         chk("acc_last", 32'(acc_last), 32'(e.last));
         chk("acc_m", 32'(acc_m), 32'(e.m));
         chk("acc_n", 32'(acc_n), 32'(e.n));
      end else begin
         chk("acc_idle", 32'(acc_valid), 0);
      end
      if (acc_valid && acc_first) first_cnt++;
      if (acc_valid && acc_last) last_cnt++;
      if (done) done_cnt++;
      if (a_rd_en) begin
         chk("b_rd_en_on", 32'(b_rd_en), 1);
         chk("a_rd_addr", 32'(a_rd_addr), 32'(16'(mdl_m * job_k + mdl_k)));
         chk("b_rd_addr", 32'(b_rd_addr), 32'(16'(mdl_n * job_k + mdl_k)));
         chk("issue_in_job", 32'(issue_cnt < job_m * job_n * job_k), 1);
         e.due   = cyc + PIPE_LAT;
         e.first = (mdl_k == 0);
         e.last  = (mdl_k == job_k - 1);
         e.m     = 8'(mdl_m);
         e.n     = 8'(mdl_n);
         sb.push_back(e);
         if (issue_cnt == 0) first_issue_cyc = cyc;
         last_issue_cyc = cyc;
         issue_cnt++;
         mdl_k++;
         if (mdl_k == job_k) begin
            mdl_k = 0;
            mdl_n++;
            if (mdl_n == job_n) begin
               mdl_n = 0;
               mdl_m++;
            end
         end
      end else begin
         chk("b_rd_en_off", 32'(b_rd_en), 0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 32'({busy, done, cfg_err, a_rd_en, b_rd_en, acc_valid, acc_first, acc_last}), 0);
      chk({tag, "_addr"}, {a_rd_addr, b_rd_addr}, 0);
      chk({tag, "_mn"}, 32'({acc_m, acc_n}), 0);
   endtask

   task automatic start_job(input int m, input int n, input int k);
      job_m = m;
      job_n = n;
      job_k = k;
      mdl_m = 0;
      mdl_n = 0;
      mdl_k = 0;
      issue_cnt = 0;
      first_cnt = 0;
      last_cnt = 0;
      cfg_m = 8'(m);
      cfg_n = 8'(n);
      cfg_k = 8'(k);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
   endtask

   task automatic finish_job(input string tag);
      int found = 0;
      int dcyc = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         @(negedge clock);
         if (done) begin
            found = 1;
            dcyc = cyc;
            chk({tag, "_busy_at_done"}, 32'(busy), 0);
         end
      end
      #1;
      chk({tag, "_done_seen"}, found, 1);
      chk({tag, "_done_latency"}, dcyc - last_issue_cyc, PIPE_LAT + 1);
      chk({tag, "_issue_count"}, issue_cnt, job_m * job_n * job_k);
      chk({tag, "_first_count"}, first_cnt, job_m * job_n);
      chk({tag, "_last_count"}, last_cnt, job_m * job_n);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      step();
      chk({tag, "_done_pulse"}, 32'({done, busy}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int saved_done;
      rst = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      cfg_m = '0;
      cfg_n = '0;
      cfg_k = '0;
      #1;
      chk_all_zero("reset");
      step();
      step();
      rst = 1'b0;
      step();

      // Single tile
      start_job(1, 1, 1);
      chk("t1_rd_en", 32'(a_rd_en), 1);
      finish_job("t1");

      // 2x2x3, no stall
      start_job(2, 2, 3);
      finish_job("t2");
      chk("t2_consecutive", last_issue_cyc - first_issue_cyc, 11);

      // 1x1x4 with a two-cycle stall in the middle of issue
      start_job(1, 1, 4);
      step();
      stall = 1'b1;
      step();
      step();
      stall = 1'b0;
      finish_job("t3");
      chk("t3_issue_span", last_issue_cyc - first_issue_cyc, 5);

      // Zero cfg field rejected
      cfg_m = 8'd2;
      cfg_n = 8'd2;
      cfg_k = 8'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("cfgk0_err", 32'({cfg_err, busy, a_rd_en}), 32'(3'b100));
      step();
      chk("cfgk0_after", 32'({cfg_err, busy, a_rd_en}), 0);
      cfg_m = 8'd0;
      cfg_k = 8'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("cfgm0_err", 32'({cfg_err, busy}), 32'(2'b10));
      step();

      // Start during busy is ignored
      start_job(2, 2, 2);
      step();
      step();
      cfg_m = 8'd1;
      cfg_n = 8'd1;
      cfg_k = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 1);
      finish_job("t4");

      // Reset in the middle of a 4x4x4 job
      saved_done = done_cnt;
      start_job(4, 4, 4);
      for (int i = 0; i < 20; i++) begin
         if (issue_cnt >= 5) break;
         step();
      end
      chk("t5_issues_before_rst", issue_cnt, 5);
      rst = 1'b1;
      #1;
      chk_all_zero("t5_rst");
      sb.delete();
      step();
      step();
      step();
      chk_all_zero("t5_held");
      rst = 1'b0;
      step();
      chk("t5_no_done", done_cnt, saved_done);
      start_job(1, 1, 1);
      finish_job("t5b");

      // Stall held throughout DRAIN
      start_job(1, 2, 2);
      for (int i = 0; i < 20; i++) begin
         if (issue_cnt >= 4) break;
         step();
      end
      stall = 1'b1;
      finish_job("t6");
      stall = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cube_seq_ctrl.md
Name: cube_seq_ctrl

Overview:
- Sequencer for the 8x8x8 cube matrix engine.
- Walks an M x N x K tile loop nest and issues one tile-pair read per cycle to the pixel (A) and weight (B) operand buffers.
- Tracks each issued tile through the fixed buffer-plus-cube latency. Emits valid/first/last/coordinate sideband aligned with the cube's acc_out, so the downstream accumulator knows when to clear, accumulate and write back.
- Sits between the layer-level command decoder and the cube/accumulator pair.

Parameters:
- CNT_W, 8, width of each tile-count config field and loop counter.
- ADDR_W, 16, operand buffer address width.
- PIPE_LAT, 3, cycles from rd_en to the matching cube acc_out being valid (1 buffer read + 2 cube).

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- cfg_m  in  CNT_W  number of M tiles (pixel-row tiles).
- cfg_n  in  CNT_W  number of N tiles (output-channel tiles).
- cfg_k  in  CNT_W  number of K tiles (reduction tiles).
- stall  in  1  when high, no new issue this cycle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last tile leaves the pipe.
- cfg_err  out  1  one-cycle pulse when start is seen with any cfg field equal to 0.
- a_rd_en  out  1  pixel buffer read strobe.
- a_rd_addr  out  ADDR_W  pixel tile address = m*cfg_k + k.
- b_rd_en  out  1  weight buffer read strobe; always equal to a_rd_en.
- b_rd_addr  out  ADDR_W  weight tile address = n*cfg_k + k.
- acc_valid  out  1  acc_out of the cube is valid this cycle.
- acc_first  out  1  with acc_valid: k==0, accumulator loads instead of adding.
- acc_last  out  1  with acc_valid: k==cfg_k-1, accumulator result to be written back.
- acc_m  out  CNT_W  m coordinate of the aligned tile.
- acc_n  out  CNT_W  n coordinate of the aligned tile.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and latched cfg 0, pipe valid bits cleared. Reset asserted mid-operation abandons the job; no done pulse.
- States:
  - IDLE: start with all cfg nonzero latches cfg, zeroes m/n/k, enters RUN, and busy=1 from the next cycle. start with any cfg zero pulses cfg_err the next cycle and stays IDLE.
  - RUN: each cycle with stall=0, drive rd_en=1 with the addresses of the current (m,n,k), then advance. k is innermost, then n, then m. When the issued tile is (cfg_m-1, cfg_n-1, cfg_k-1), go to DRAIN. With stall=1, rd_en=0 and counters hold.
  - DRAIN: no issue; stall ignored. Leave when all PIPE_LAT pipe stages are empty.
  - DONE: one cycle, done=1; busy drops in the same cycle; return to IDLE.
- start outside IDLE is ignored.
- Addressing is incremental, with no multipliers:
  - a_base and b_base registers; address = base + k.
  - k wrap: b_base += cfg_k.
  - n wrap: b_base = 0, a_base += cfg_k.
  - Address arithmetic is modulo 2^ADDR_W; overflow is the host's responsibility.
- Tracking pipe:
  - PIPE_LAT-deep shift register of {valid, first, last, m, n}.
  - It advances every cycle unconditionally; the cube has no enable.
  - Stage 0 is loaded with rd_en and the issued tile's fields.
  - The last stage drives acc_*, so acc_valid is exactly rd_en delayed PIPE_LAT cycles.
- Stall only creates bubbles: acc_valid gaps appear, ordering is unchanged, and in-flight tiles are never dropped.
- cfg_k==1: acc_first and acc_last are both 1 on every valid tile.
- Total issue count is exactly cfg_m*cfg_n*cfg_k.
- With no stalls, done is asserted PIPE_LAT+1 cycles after the last issue.

Decomposition:
- Shared package cube_pkg:
  - CNT_W, ADDR_W, PIPE_LAT defaults.
  - State encoding constants (IDLE/RUN/DRAIN/DONE).
  - The tile-tag struct layout {valid, first, last, m, n} as width constants.
- One sub-module, cube_tag_pipe: the parameterised PIPE_LAT-stage tag shift register, with async reset clearing valid bits only.

Test Plan:
- cfg 1/1/1, start, no stall -> one rd_en at addresses a=0, b=0. acc_valid, acc_first and acc_last all 1 exactly 3 cycles later; done the next cycle.
- cfg 2/2/3, no stall:
  - 12 consecutive issues.
  - a_rd_addr sequence 0,1,2,0,1,2,3,4,5,3,4,5.
  - b_rd_addr sequence 0,1,2,3,4,5,0,1,2,3,4,5.
  - acc_first on every 3rd tile starting with the 1st; acc_last on every 3rd ending with the 12th.
  - (acc_m, acc_n) order: (0,0),(0,1),(1,0),(1,1).
- cfg 1/1/4 with stall high on issue cycles 2-3 -> 4 issues over 6 cycles; acc_valid pattern 1,1,0,0,1,1 delayed by 3; exactly one acc_first and one acc_last.
- start with cfg_k=0 -> cfg_err pulse; busy stays 0; no rd_en. A second start during busy of a 2/2/2 job is ignored, and exactly 8 issues occur.
- rst asserted in RUN after 5 issues of a 4/4/4 job -> all outputs 0 immediately; no done. A new 1/1/1 job afterwards completes normally.
- stall held high throughout DRAIN -> pipe still empties; done asserted PIPE_LAT+1 cycles after the final issue.
